// File: rtl/dual_issue_ctrl_if.sv
// Decode-pair / issue-lane bundle for the dual-issue controller.
// The master side is the decode pair register; the slave side is the issue controller.
interface dual_issue_ctrl_if #(
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned IWIDTH       = 32,
  parameter int unsigned PCWIDTH      = 32,
  parameter int unsigned CWIDTH       = 16
);
  logic                    ds_i_valid;
  logic                    ds_o_ready;
  logic [IWIDTH-1:0]       ds_i_instr_1;
  logic [IWIDTH-1:0]       ds_i_instr_2;
  logic [PCWIDTH-1:0]      ds_i_pc;
  logic                    ds_i_we_1;
  logic [AWIDTH-1:0]       ds_i_addr_rd_1;
  logic [AWIDTH-1:0]       ds_i_addr_rs_2;
  logic [AWIDTH-1:0]       ds_i_addr_rt_2;
  logic [OPCODE_WIDTH-1:0] ds_i_opcode_2;
  logic                    ds_i_stall;
  logic                    ds_i_flush;
  logic                    ds_o_valid_0;
  logic [IWIDTH-1:0]       ds_o_instr_0;
  logic [PCWIDTH-1:0]      ds_o_pc_0;
  logic                    ds_o_valid_1;
  logic [IWIDTH-1:0]       ds_o_instr_1;
  logic [PCWIDTH-1:0]      ds_o_pc_1;
  logic [CWIDTH-1:0]       ds_o_split_cnt;

  modport master (
    output ds_i_valid, ds_i_instr_1, ds_i_instr_2, ds_i_pc, ds_i_we_1,
           ds_i_addr_rd_1, ds_i_addr_rs_2, ds_i_addr_rt_2, ds_i_opcode_2,
           ds_i_stall, ds_i_flush,
    input  ds_o_ready, ds_o_valid_0, ds_o_instr_0, ds_o_pc_0,
           ds_o_valid_1, ds_o_instr_1, ds_o_pc_1, ds_o_split_cnt
  );

  modport slave (
    input  ds_i_valid, ds_i_instr_1, ds_i_instr_2, ds_i_pc, ds_i_we_1,
           ds_i_addr_rd_1, ds_i_addr_rs_2, ds_i_addr_rt_2, ds_i_opcode_2,
           ds_i_stall, ds_i_flush,
    output ds_o_ready, ds_o_valid_0, ds_o_instr_0, ds_o_pc_0,
           ds_o_valid_1, ds_o_instr_1, ds_o_pc_1, ds_o_split_cnt
  );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Issue-stage controller: issues decoded pairs together, or splits them over two
// issue cycles when slot 2 reads slot 1's destination or is a JR.
module dual_issue_ctrl #(
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned IWIDTH       = 32,
  parameter int unsigned PCWIDTH      = 32,
  parameter int unsigned CWIDTH       = 16,
  parameter logic [OPCODE_WIDTH-1:0] JR_OPCODE = OPCODE_WIDTH'(8)
) (
  input logic ds_clk,
  input logic ds_rst,
  dual_issue_ctrl_if.slave ds
);

  typedef enum logic {RUN, SPLIT} state_t;

  state_t               state_q, state_d;
  logic                 valid0_q, valid0_d;
  logic                 valid1_q, valid1_d;
  logic [IWIDTH-1:0]    instr0_q, instr0_d;
  logic [IWIDTH-1:0]    instr1_q, instr1_d;
  logic [PCWIDTH-1:0]   pc0_q, pc0_d;
  logic [PCWIDTH-1:0]   pc1_q, pc1_d;
  logic [IWIDTH-1:0]    hold_instr_q, hold_instr_d;
  logic [PCWIDTH-1:0]   hold_pc_q, hold_pc_d;
  logic [CWIDTH-1:0]    cnt_q, cnt_d;

  logic                 raw_c;
  logic                 conflict_c;
  logic                 ready_c;
  logic                 accept_c;
  logic [PCWIDTH-1:0]   pc_slot2_c;

  // Slot-2 hazard detection; r0 is never a real dependency.
  assign raw_c      = ds.ds_i_we_1 && (ds.ds_i_addr_rd_1 != '0) &&
                      ((ds.ds_i_addr_rd_1 == ds.ds_i_addr_rs_2) ||
                       (ds.ds_i_addr_rd_1 == ds.ds_i_addr_rt_2));
  assign conflict_c = raw_c || (ds.ds_i_opcode_2 == JR_OPCODE);
  assign ready_c    = (state_q == RUN) && !ds.ds_i_stall && !ds.ds_i_flush;
  assign accept_c   = ds.ds_i_valid && ready_c;
  assign pc_slot2_c = ds.ds_i_pc + PCWIDTH'(4);

  always_ff @(posedge ds_clk) begin
    if (ds_rst) begin
      state_q      <= RUN;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      instr0_q     <= '0;
      instr1_q     <= '0;
      pc0_q        <= '0;
      pc1_q        <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      instr0_q     <= instr0_d;
      instr1_q     <= instr1_d;
      pc0_q        <= pc0_d;
      pc1_q        <= pc1_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  // Priority: flush > stall > sequencing; stall simply holds every register.
  always_comb begin
    state_d      = state_q;
    valid0_d     = valid0_q;
    valid1_d     = valid1_q;
    instr0_d     = instr0_q;
    instr1_d     = instr1_q;
    pc0_d        = pc0_q;
    pc1_d        = pc1_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    cnt_d        = cnt_q;

    if (ds.ds_i_flush) begin
      state_d  = RUN;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end else if (!ds.ds_i_stall) begin
      unique case (state_q)
        RUN: begin
          if (accept_c) begin
            valid0_d = 1'b1;
            instr0_d = ds.ds_i_instr_1;
            pc0_d    = ds.ds_i_pc;
            if (conflict_c) begin
              valid1_d     = 1'b0;
              hold_instr_d = ds.ds_i_instr_2;
              hold_pc_d    = pc_slot2_c;
              state_d      = SPLIT;
              cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CWIDTH'(1);
            end else begin
              valid1_d = 1'b1;
              instr1_d = ds.ds_i_instr_2;
              pc1_d    = pc_slot2_c;
            end
          end else begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
          end
        end
        SPLIT: begin
          valid0_d = 1'b1;
          instr0_d = hold_instr_q;
          pc0_d    = hold_pc_q;
          valid1_d = 1'b0;
          state_d  = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign ds.ds_o_ready     = ready_c;
  assign ds.ds_o_valid_0   = valid0_q;
  assign ds.ds_o_instr_0   = instr0_q;
  assign ds.ds_o_pc_0      = pc0_q;
  assign ds.ds_o_valid_1   = valid1_q;
  assign ds.ds_o_instr_1   = instr1_q;
  assign ds.ds_o_pc_1      = pc1_q;
  assign ds.ds_o_split_cnt = cnt_q;

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
- Issue-stage controller for the dual-issue pipeline. It sits between the decode pair register and the two execute lanes.
- Each cycle it accepts one decoded instruction pair and checks slot 2 for a RAW dependency on slot 1, or for a JR in slot 2.
- An independent pair is issued together. A dependent pair is split: slot 1 issues first, and the held slot 2 issues alone in the following issue cycle.
- It also counts split events for performance monitoring.

Parameters:
- AWIDTH, 5, register address width (matches `AWIDTH).
- OPCODE_WIDTH, 6, opcode width (matches `OPCODE_WIDTH).
- IWIDTH, 32, instruction word width.
- PCWIDTH, 32, program counter width.
- CWIDTH, 16, split-event counter width.

Ports:
- ds_clk  input  1  clock; all state updates on the rising edge.
- ds_rst  input  1  reset; synchronous, active-high.
- ds_i_valid  input  1  decode pair is valid.
- ds_o_ready  output  1  controller accepts the pair this cycle.
- ds_i_instr_1  input  IWIDTH  slot-1 instruction word.
- ds_i_instr_2  input  IWIDTH  slot-2 instruction word.
- ds_i_pc  input  PCWIDTH  PC of the slot-1 instruction; slot 2 is PC+4.
- ds_i_we_1  input  1  slot-1 instruction writes a register.
- ds_i_addr_rd_1  input  AWIDTH  slot-1 destination register.
- ds_i_addr_rs_2  input  AWIDTH  slot-2 source register rs.
- ds_i_addr_rt_2  input  AWIDTH  slot-2 source register rt.
- ds_i_opcode_2  input  OPCODE_WIDTH  slot-2 opcode.
- ds_i_stall  input  1  execute lanes cannot take a new issue.
- ds_i_flush  input  1  branch/jump redirect; discard all pending work.
- ds_o_valid_0  output  1  lane 0 issue valid.
- ds_o_instr_0  output  IWIDTH  lane 0 instruction.
- ds_o_pc_0  output  PCWIDTH  lane 0 PC.
- ds_o_valid_1  output  1  lane 1 issue valid.
- ds_o_instr_1  output  IWIDTH  lane 1 instruction.
- ds_o_pc_1  output  PCWIDTH  lane 1 PC.
- ds_o_split_cnt  output  CWIDTH  saturating count of split events.

Behaviour:
- Conflict rule (combinational), conflict = 1 when either holds:
  - ds_i_we_1=1 and ds_i_addr_rd_1≠0 and (rd_1==rs_2 or rd_1==rt_2). rd_1 equal to both rs_2 and rt_2 is also a conflict.
  - ds_i_opcode_2==`JR, regardless of the rule above.
- States: RUN, SPLIT. Reset state is RUN.
- ds_o_ready = (state==RUN) and !ds_i_stall and !ds_i_flush.
- Accept = ds_i_valid and ds_o_ready.
- RUN, accept, no conflict: next cycle valid_0=1 with instr_1/pc, and valid_1=1 with instr_2/pc+4. Stay in RUN.
- RUN, accept, conflict:
  - Next cycle valid_0=1 with instr_1/pc, and valid_1=0.
  - instr_2 and pc+4 are latched into the hold register.
  - State goes to SPLIT; split_cnt increments.
- RUN, no accept, !ds_i_stall: both valids go to 0 next cycle.
- SPLIT, !ds_i_stall: next cycle valid_0=1 with the held instruction and PC, valid_1=0. State returns to RUN. No new pair is accepted in this cycle.
- Any state, ds_i_stall=1 (and no flush): all outputs, the hold register and the state are unchanged.
- Latency: 1 cycle from accept to issue. A split pair occupies 2 issue cycles, or more if stalled.
- ds_i_flush=1:
  - Next cycle both valids are 0, the hold register is invalidated and the state is RUN.
  - Flush overrides stall and accept; a pair presented in the flush cycle is dropped.
- Lane data outputs are don't-care while their valid is 0. Their reset value is 0.
- split_cnt saturates at 2^CWIDTH-1 and is cleared only by reset; flush does not clear it.
- ds_rst=1 (takes effect at the next edge, even mid-SPLIT):
  - valid_0 = valid_1 = 0.
  - All lane data outputs = 0, split_cnt = 0.
  - State RUN, hold register cleared.
- Priority: reset > flush > stall > normal sequencing.
- An issue of lane 1 without lane 0 never occurs.

Test Plan:
- Independent pair: we_1=1, rd_1=8, rs_2=9, rt_2=10, opcode_2=0, pc=0x100, valid=1. Required: next cycle valid_0=valid_1=1, pc_0=0x100, pc_1=0x104, split_cnt=0.
- RAW split:
  - Stimulus: rd_1=8, rs_2=8, rt_2=3, we_1=1.
  - Cycle+1: valid_0=1 with instr_1, valid_1=0, ready=0.
  - Cycle+2: valid_0=1 with instr_2, pc_0=pc+4.
  - split_cnt=1.
- Non-conflicts and double match:
  - rd_1=0 matching rs_2=0 → no split.
  - we_1=0 with rd_1==rt_2 → no split.
  - rd_1=rs_2=rt_2=5, we_1=1 → split.
  - opcode_2=`JR with unrelated registers → split.
- Stall during SPLIT: hold ds_i_stall=1 for 3 cycles after the split. Required: outputs frozen, ready=0; the held instruction issues one cycle after stall drops.
- Flush in SPLIT state: assert ds_i_flush. Required: next cycle valid_0=valid_1=0, state RUN; the held instruction is never issued; split_cnt is unchanged.
- Reset mid-split and counter saturation:
  - ds_rst in SPLIT → all outputs 0 next cycle.
  - With CWIDTH=2, force 5 splits → split_cnt=3.
